sparse_chunk_encoder: RTL

SPARSE_CHUNK_ENCODER -- requirements
Module: sparse_chunk_encoder

---
 rtl/sparse_chunk_encoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/sparse_chunk_encoder.sv
// Sparse chunk encoder: collects up to CHUNK_SIZE dense elements, records a
// bitmap of which ones were nonzero and packs the nonzero values towards
// index 0. The encoded chunk is held on the output until it is accepted.
module sparse_chunk_encoder #(
  parameter int CHUNK_SIZE = 128,
  parameter int Q          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Q-1:0]                  in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHUNK_SIZE-1:0]         out_sparsemap,
  output logic [Q-1:0]                  out_data [CHUNK_SIZE],
  output logic [$clog2(CHUNK_SIZE):0]   out_nnz
);

  localparam int IW = $clog2(CHUNK_SIZE);
  localparam int NW = IW + 1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic [NW-1:0]         nnz_q;
  logic [NW-1:0]         nnz_d;
  logic [CHUNK_SIZE-1:0] sparsemap_q;
  logic [CHUNK_SIZE-1:0] sparsemap_d;

  logic accept;
  logic in_nonzero;
  logic final_beat;
  logic out_fire;

  // in_ready_q is only ever high in COLLECT, so it alone qualifies a beat.
  assign accept     = in_valid & in_ready_q;
  assign in_nonzero = (in_data != '0);
  // in_last on the final slot is harmless: both terms lead to the same result.
  assign final_beat = (idx_q == IW'(CHUNK_SIZE - 1)) | in_last;
  assign out_fire   = out_valid_q & out_ready;

  assign idx_d       = final_beat ? '0 : idx_q + IW'(1);
  assign nnz_d       = nnz_q + NW'(in_nonzero);
  assign sparsemap_d = sparsemap_q | (CHUNK_SIZE'(in_nonzero) << idx_q);

  // Control FSM: element index, nonzero count, bitmap and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      nnz_q       <= '0;
      sparsemap_q <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            idx_q       <= idx_d;
            nnz_q       <= nnz_d;
            sparsemap_q <= sparsemap_d;
            if (final_beat) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            nnz_q       <= '0;
            sparsemap_q <= '0;
          end
        end
      endcase
    end
  end

  // One storage slot per compacted position; slots past nnz stay zero.
  for (genvar gi = 0; gi < CHUNK_SIZE; gi++) begin : g_slot
    logic [Q-1:0] slot_q;

    // Capture the nonzero beat whose compacted position is this slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_q <= '0;
      end else if (out_fire) begin
        slot_q <= '0;
      end else if (accept && in_nonzero && (nnz_q == NW'(gi))) begin
        slot_q <= in_data;
      end
    end

    assign out_data[gi] = slot_q;
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_sparsemap = sparsemap_q;
  assign out_nnz       = nnz_q;

endmodule
